// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with N combinational read
// ports, one synchronous write port, an optional same-cycle write-to-read
// bypass, and a per-register pending (scoreboard) bit for hazard detection.
// This block has no valid/ready handshakes: every input is sampled on each
// rising edge of clk, and the read ports are purely combinational.
module regfile_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*AW-1:0]     rs_addr_i,
  output logic [NUM_RD*XLEN-1:0]   rs_data_o,
  output logic [NUM_RD-1:0]        rs_busy_o,
  input  logic                     wr_en_i,
  input  logic [AW-1:0]            rd_addr_i,
  input  logic [XLEN-1:0]          wr_data_i,
  input  logic                     issue_en_i,
  input  logic [AW-1:0]            issue_rd_i,
  input  logic                     flush_i,
  output logic [NREGS-1:0]         busy_vec_o
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pend;
  logic [AW-1:0]    rd_addr;
  logic             wr_hit;

  // Storage: async clear, single write port; writes to x0 are dropped.
  // A flush does not block the data write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else if (wr_en_i && (rd_addr_i != '0)) begin
      regs[rd_addr_i] <= wr_data_i;
    end
  end

  // Scoreboard: flush beats issue, issue beats writeback (the writeback
  // belongs to an older instruction). Bit 0 is never set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend <= '0;
    end else begin
      pend[0] <= 1'b0;
      for (int r = 1; r < NREGS; r++) begin
        if (flush_i) begin
          pend[r] <= 1'b0;
        end else if (issue_en_i && (issue_rd_i == AW'(r))) begin
          pend[r] <= 1'b1;
        end else if (wr_en_i && (rd_addr_i == AW'(r))) begin
          pend[r] <= 1'b0;
        end
      end
    end
  end

  // Read ports: x0 reads zero; a same-cycle writeback hit always clears
  // busy (avoids deadlock) and forwards the write data only when BYPASS=1.
  // Outputs are forced to zero while reset is held so a pending write
  // cannot leak through the bypass path.
  always_comb begin
    rs_data_o = '0;
    rs_busy_o = '0;
    rd_addr   = '0;
    wr_hit    = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_addr = rs_addr_i[k*AW +: AW];
      wr_hit  = wr_en_i && (rd_addr_i == rd_addr);
      if (!reset_n || (rd_addr == '0)) begin
        rs_data_o[k*XLEN +: XLEN] = '0;
        rs_busy_o[k]              = 1'b0;
      end else if (wr_hit) begin
        rs_data_o[k*XLEN +: XLEN] = (BYPASS != 0) ? wr_data_i : regs[rd_addr];
        rs_busy_o[k]              = 1'b0;
      end else begin
        rs_data_o[k*XLEN +: XLEN] = regs[rd_addr];
        rs_busy_o[k]              = pend[rd_addr];
      end
    end
  end

  assign busy_vec_o = pend;

endmodule
